// File: rtl/ctag_store_if.sv
// ctag_store_if: request/response bundle between the cache control sequencer and the tag store.
interface ctag_store_if #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 13
);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag_in;
    logic             lookup;
    logic             write;
    logic             inval;
    logic             perr_inj;
    logic             flush_req;
    logic             busy;
    logic             rd_valid;
    logic             hit;
    logic             perr;
    logic [TAG_W-1:0] q_tag;
    logic             q_valid;
    modport master (
        output idx, tag_in, lookup, write, inval, perr_inj, flush_req,
        input  busy, rd_valid, hit, perr, q_tag, q_valid
    );
    modport slave (
        input  idx, tag_in, lookup, write, inval, perr_inj, flush_req,
        output busy, rd_valid, hit, perr, q_tag, q_valid
    );
endinterface

// File: rtl/ctag_store.sv
// ctag_store: parametrised cache tag store with valid bit, even parity,
// registered lookup/compare and a flush sequencer run after reset or on request.
module ctag_store #(
    parameter int IDX_W          = 10,
    parameter int TAG_W          = 13,
    parameter int FLUSH_ON_RESET = 1
) (
    input logic          clk,
    input logic          nRST,
    ctag_store_if.slave  b
);
    localparam int DEPTH = 2 ** IDX_W;
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic               pend;
    logic [TAG_W+1:0]   mem [DEPTH];
    logic [TAG_W+1:0]   rd;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_bad;
    assign rd     = mem[b.idx];
    assign rd_tag = rd[TAG_W-1:0];
    assign rd_bad = ^rd;
    assign b.busy = state == FLUSH;
    // pend turns reset release into a flush start on the first clock edge
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= FLUSH_ON_RESET != 0;
            b.rd_valid <= 1'b0;
            b.hit      <= 1'b0;
            b.perr     <= 1'b0;
            b.q_tag    <= '0;
            b.q_valid  <= 1'b0;
        end else begin
            pend       <= 1'b0;
            b.rd_valid <= 1'b0;
            if (state == FLUSH) begin
                cnt <= cnt + 1'b1;
                if (cnt == '1) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else begin
                if (pend || b.flush_req) begin
                    state <= FLUSH;
                    cnt   <= '0;
                end
                if (b.lookup) begin
                    b.rd_valid <= 1'b1;
                    b.q_tag    <= rd_tag;
                    b.q_valid  <= rd[TAG_W];
                    b.perr     <= rd_bad;
                    b.hit      <= rd[TAG_W] && rd_tag == b.tag_in && !rd_bad;
                end
            end
        end
    end
    // array is not reset; read-before-write falls out of the combinational read above
    always_ff @(posedge clk) begin
        if (nRST) begin
            if (state == FLUSH)
                mem[cnt] <= '0;
            else if (b.inval)
                mem[b.idx] <= {^rd_tag, 1'b0, rd_tag};
            else if (b.write)
                mem[b.idx] <= {~^b.tag_in ^ b.perr_inj, 1'b1, b.tag_in};
        end
    end
endmodule

// File: tb/tb_ctag_store.sv
// tb_ctag_store: directed self-checking bench for ctag_store at default parameters.
module tb_ctag_store;
    logic clk = 1'b0;
    logic nRST = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    int   nb;
    ctag_store_if #(.IDX_W(10), .TAG_W(13)) b ();
    ctag_store #(.IDX_W(10), .TAG_W(13), .FLUSH_ON_RESET(1)) dut (
        .clk  (clk),
        .nRST (nRST),
        .b    (b.slave)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // apply one cycle of stimulus, then sample 1ns after the edge
    task automatic cyc(input logic l, input logic w, input logic iv, input logic pi,
                       input logic fr, input logic [9:0] ix, input logic [12:0] tg);
        b.lookup = l; b.write = w; b.inval = iv; b.perr_inj = pi; b.flush_req = fr;
        b.idx = ix; b.tag_in = tg;
        @(posedge clk); #1;
        b.lookup = 0; b.write = 0; b.inval = 0; b.perr_inj = 0; b.flush_req = 0;
    endtask

    // counts remaining busy samples, bounded so a stuck busy cannot hang the run
    task automatic count_busy(inout int n);
        for (int k = 0; k < 2000; k++) begin
            if (!b.busy) break;
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        b.lookup = 0; b.write = 0; b.inval = 0; b.perr_inj = 0; b.flush_req = 0;
        b.idx = '0; b.tag_in = '0;
        #2 nRST = 1'b0;
        #1;
        chk("reset busy", 32'(b.busy), 0);
        chk("reset rd_valid", 32'(b.rd_valid), 0);
        chk("reset q_tag", 32'(b.q_tag), 0);
        @(posedge clk); @(posedge clk); #1;
        nRST = 1'b1;
        // test 1: power-up flush length
        nb = 0;
        @(posedge clk); #1;
        count_busy(nb);
        chk("t1 busy cycles", 32'(nb), 1024);
        cyc(1, 0, 0, 0, 0, 10'h3FF, 13'h0);
        chk("t1 rd_valid", 32'(b.rd_valid), 1);
        chk("t1 hit", 32'(b.hit), 0);
        chk("t1 q_valid", 32'(b.q_valid), 0);
        chk("t1 perr", 32'(b.perr), 0);
        // test 2: write then hit / tag mismatch
        cyc(0, 1, 0, 0, 0, 10'h155, 13'h0ABC);
        cyc(1, 0, 0, 0, 0, 10'h155, 13'h0ABC);
        chk("t2 hit", 32'(b.hit), 1);
        chk("t2 q_valid", 32'(b.q_valid), 1);
        cyc(1, 0, 0, 0, 0, 10'h155, 13'h0ABD);
        chk("t2 miss hit", 32'(b.hit), 0);
        chk("t2 miss q_tag", 32'(b.q_tag), 32'h0ABC);
        cyc(0, 0, 0, 0, 0, 10'h155, 13'h0);
        chk("t2 idle rd_valid", 32'(b.rd_valid), 0);
        chk("t2 idle q_tag hold", 32'(b.q_tag), 32'h0ABC);
        // test 3: read-before-write
        cyc(0, 1, 0, 0, 0, 10'h020, 13'h0011);
        cyc(1, 1, 0, 0, 0, 10'h020, 13'h0022);
        chk("t3 old q_tag", 32'(b.q_tag), 32'h0011);
        chk("t3 old hit", 32'(b.hit), 0);
        cyc(1, 0, 0, 0, 0, 10'h020, 13'h0022);
        chk("t3 new q_tag", 32'(b.q_tag), 32'h0022);
        chk("t3 new hit", 32'(b.hit), 1);
        // test 4: injected parity error, cleared by inval
        cyc(0, 1, 0, 1, 0, 10'h007, 13'h1FFF);
        cyc(1, 0, 0, 0, 0, 10'h007, 13'h1FFF);
        chk("t4 perr", 32'(b.perr), 1);
        chk("t4 hit", 32'(b.hit), 0);
        chk("t4 q_valid", 32'(b.q_valid), 1);
        cyc(0, 0, 1, 0, 0, 10'h007, 13'h0);
        cyc(1, 0, 0, 0, 0, 10'h007, 13'h1FFF);
        chk("t4 inval perr", 32'(b.perr), 0);
        chk("t4 inval q_valid", 32'(b.q_valid), 0);
        chk("t4 inval q_tag", 32'(b.q_tag), 32'h1FFF);
        // test 5: requested flush, ops during busy ignored
        cyc(0, 0, 0, 0, 1, 10'h0, 13'h0);
        nb = 0;
        if (b.busy) nb++;
        cyc(0, 1, 0, 0, 0, 10'h100, 13'h0005);
        if (b.busy) nb++;
        cyc(1, 0, 0, 0, 0, 10'h155, 13'h0ABC);
        chk("t5 busy rd_valid", 32'(b.rd_valid), 0);
        if (b.busy) nb++;
        @(posedge clk); #1;
        count_busy(nb);
        chk("t5 busy cycles", 32'(nb), 1024);
        cyc(1, 0, 0, 0, 0, 10'h155, 13'h0ABC);
        chk("t5 155 hit", 32'(b.hit), 0);
        chk("t5 155 q_valid", 32'(b.q_valid), 0);
        cyc(1, 0, 0, 0, 0, 10'h020, 13'h0022);
        chk("t5 020 hit", 32'(b.hit), 0);
        cyc(1, 0, 0, 0, 0, 10'h100, 13'h0005);
        chk("t5 100 q_valid", 32'(b.q_valid), 0);
        // test 6: reset in the middle of a flush
        cyc(0, 1, 0, 0, 0, 10'h155, 13'h0ABC);
        cyc(1, 0, 0, 0, 0, 10'h155, 13'h0ABC);
        chk("t6 pre hit", 32'(b.hit), 1);
        cyc(0, 0, 0, 0, 1, 10'h0, 13'h0);
        repeat (499) begin @(posedge clk); #1; end
        chk("t6 mid busy", 32'(b.busy), 1);
        chk("t6 mid hit hold", 32'(b.hit), 1);
        nRST = 1'b0;
        #1;
        chk("t6 async busy", 32'(b.busy), 0);
        chk("t6 async hit", 32'(b.hit), 0);
        chk("t6 async q_tag", 32'(b.q_tag), 0);
        chk("t6 async q_valid", 32'(b.q_valid), 0);
        @(posedge clk); #1;
        nRST = 1'b1;
        nb = 0;
        @(posedge clk); #1;
        count_busy(nb);
        chk("t6 busy cycles", 32'(nb), 1024);
        cyc(0, 1, 0, 0, 0, 10'h033, 13'h0044);
        cyc(0, 1, 1, 0, 0, 10'h033, 13'h0055);
        cyc(1, 0, 0, 0, 0, 10'h033, 13'h0044);
        chk("t6 w+i q_valid", 32'(b.q_valid), 0);
        chk("t6 w+i q_tag", 32'(b.q_tag), 32'h0044);
        chk("t6 w+i hit", 32'(b.hit), 0);
        chk("t6 w+i perr", 32'(b.perr), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ctag_store.md
Name: ctag_store

Overview:
- Parametrised cache tag store, the successor to the fixed 1K x 14 bit-sliced tag array.
- Adds per-entry valid bit, stored even parity, registered lookup with tag compare and hit/parity-error flags.
- Adds a hardware flush sequencer that invalidates every entry after reset and on request.
- Sits between the cache control microsequencer and the memory interface; one lookup or one update per clock.

Parameters:
- IDX_W, 10, index width; depth = 2**IDX_W entries.
- TAG_W, 13, stored tag width.
- FLUSH_ON_RESET, 1, 1 = start a full flush when nRST deasserts; 0 = entries power up undefined.

Ports:
- clk  in  1  sole clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- idx  in  IDX_W  entry index for lookup/write/inval.
- tag_in  in  TAG_W  tag for compare or write.
- lookup  in  1  read entry idx, compare against tag_in.
- write  in  1  store tag_in at idx, set valid.
- inval  in  1  clear valid at idx.
- perr_inj  in  1  diagnostic: with write, store inverted parity.
- flush_req  in  1  single-cycle pulse; start full flush.
- busy  out  1  flush in progress.
- rd_valid  out  1  lookup result valid this cycle.
- hit  out  1  valid and tag match and parity good.
- perr  out  1  parity mismatch on the looked-up entry.
- q_tag  out  TAG_W  stored tag of the looked-up entry.
- q_valid  out  1  stored valid bit of the looked-up entry.

Behaviour:
- Entry format: {par, valid, tag}. par = even parity over {valid, tag}, i.e. XOR of those bits; inverted when perr_inj=1.
- Async reset: busy, rd_valid, hit, perr, q_valid = 0; q_tag = 0; flush counter = 0; FSM in IDLE. Array contents are not reset.
- FSM IDLE:
  - nRST deassert with FLUSH_ON_RESET=1 -> FLUSH on the first clock edge.
  - flush_req=1 -> FLUSH on the next edge.
- FSM FLUSH:
  - One entry per cycle, counter 0..2**IDX_W-1. Each step writes {par(0,0),0,0}.
  - busy=1 throughout FLUSH.
  - After the last index, return to IDLE. busy falls the cycle after the last entry is written.
  - Total busy = 2**IDX_W cycles; 1024 at defaults.
- While busy:
  - lookup, write, inval and flush_req are ignored. No state change.
  - rd_valid stays 0.
- Lookup latency: 1 cycle. On the edge after lookup=1, rd_valid=1 with q_tag, q_valid, hit, perr for that entry.
  - rd_valid is 0 in any cycle without a preceding accepted lookup.
  - hit, perr, q_tag, q_valid hold their last values when rd_valid=0.
- hit = q_valid & (q_tag == tag_in registered with the lookup) & ~perr.
- perr is a one-cycle flag alongside rd_valid. An entry with bad parity always reports hit=0.
- Same-cycle priority in IDLE: inval > write. Both asserted -> entry invalidated, tag unchanged.
- Lookup with write or inval to the same idx in the same cycle -> lookup returns the old contents (read-before-write). The new contents are visible to the next lookup.
- inval rewrites par to match {0, old tag}, which clears any injected parity error.
- Reset asserted mid-flush: FSM to IDLE immediately. On release with FLUSH_ON_RESET=1 the flush restarts from index 0.
- Index and counter arithmetic is unsigned IDX_W. The counter never wraps past the top index; the terminal compare ends FLUSH.

Test Plan:
1. Reset release, FLUSH_ON_RESET=1, defaults -> busy=1 for exactly 1024 cycles. Then lookup idx=0x3FF, tag=0 -> rd_valid=1, hit=0, q_valid=0, perr=0.
2. write idx=0x155 tag=0x0ABC; next cycle lookup idx=0x155 tag=0x0ABC -> hit=1. Lookup with tag=0x0ABD -> hit=0, q_tag=0x0ABC.
3. write plus lookup same idx 0x020 (old tag 0x0011, new 0x0022) in one cycle -> result q_tag=0x0011. Following lookup -> q_tag=0x0022.
4. write idx=0x007 tag=0x1FFF with perr_inj=1; lookup -> perr=1, hit=0, q_valid=1. inval idx=0x007 then lookup -> perr=0, q_valid=0.
5. flush_req after several writes -> busy 1024 cycles, lookups/writes issued during busy have no effect. All previously written indices then miss.
6. nRST low at flush step 500 -> outputs cleared asynchronously. On release busy lasts a full 1024 cycles. write and inval same idx in one cycle -> entry invalid.
